// File: rtl/partsel_rmw_arbiter_if.sv
// Requester-side port bundle for the part-select read-modify-write engine.
// The requester drives the master modport and the engine drives the slave modport.
interface partsel_rmw_arbiter_if #(
    parameter int FW = 8,
    parameter int OW = 5,
    parameter int LW = 3
);
    logic          valid;
    logic          ready;
    logic          write;
    logic [OW-1:0] offset;
    logic [LW-1:0] len;
    logic [FW-1:0] wdata;
    logic          rvalid;
    logic [FW-1:0] rdata;
    logic          rerr;

    modport master (
        output valid, write, offset, len, wdata,
        input  ready, rvalid, rdata, rerr
    );

    modport slave (
        input  valid, write, offset, len, wdata,
        output ready, rvalid, rdata, rerr
    );
endinterface

// File: rtl/partsel_rmw_arbiter.sv
// Shared bitfield extract/insert engine for one control word, arbitrated
// round-robin between two requesters and sequenced IDLE -> EXEC -> RESP.
module partsel_rmw_arbiter #(
    parameter int              DW   = 32,
    parameter int              FW   = 8,
    parameter int              OW   = $clog2(DW),
    parameter int              LW   = $clog2(FW),
    parameter logic [DW-1:0]   INIT = {DW{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    partsel_rmw_arbiter_if.slave  a,
    partsel_rmw_arbiter_if.slave  b,
    output logic [DW-1:0]         word,
    output logic                  busy
);
    localparam int XW = DW + FW;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          gnt_b, hs, a_rdy, b_rdy;
    logic [DW-1:0] word_q;

    logic          id_q, wr_q;
    logic [OW-1:0] off_q;
    logic [LW-1:0] len_q;
    logic [FW-1:0] wdata_q;
    logic [FW-1:0] rdata_q;
    logic          rerr_q;

    logic [LW:0]   width;
    logic [FW-1:0] mask_f;
    logic [XW-1:0] word_x, mask_x, data_x;
    logic [FW-1:0] field;
    logic [DW-1:0] word_wr;
    logic [OW+1:0] end_pos;
    logic          resp;

    // ptr_q = 1 means B held the last grant, so A wins the next tie
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_b   = 1'b0;
        hs      = 1'b0;
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (a.valid || b.valid) begin
                    gnt_b   = b.valid && (!a.valid || !ptr_q);
                    a_rdy   = !gnt_b;
                    b_rdy   = gnt_b;
                    hs      = 1'b1;
                    ptr_d   = gnt_b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            word_q  <= INIT;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == S_EXEC && wr_q)
                word_q <= word_wr;
        end
    end

    // Field arithmetic is done FW bits wider so fields past the top bit
    // fall off instead of wrapping to bit 0.
    assign width   = (LW+1)'({1'b0, len_q}) + (LW+1)'(1);
    assign mask_f  = ~({FW{1'b1}} << width);
    assign word_x  = {{FW{1'b0}}, word_q};
    assign mask_x  = {{DW{1'b0}}, mask_f} << off_q;
    assign data_x  = {{DW{1'b0}}, wdata_q & mask_f} << off_q;
    assign field   = FW'(word_x >> off_q) & mask_f;
    assign word_wr = DW'((word_x & ~mask_x) | data_x);
    assign end_pos = (OW+2)'(off_q) + (OW+2)'(width);

    always_ff @(posedge clk) begin
        if (hs) begin
            id_q    <= gnt_b;
            wr_q    <= gnt_b ? b.write  : a.write;
            off_q   <= gnt_b ? b.offset : a.offset;
            len_q   <= gnt_b ? b.len    : a.len;
            wdata_q <= gnt_b ? b.wdata  : a.wdata;
        end
        if (state_q == S_EXEC) begin
            rdata_q <= field;
            rerr_q  <= end_pos > (OW+2)'(DW);
        end
    end

    // Response outputs are gated by state, so they read zero outside RESP
    assign resp     = (state_q == S_RESP);
    assign a.ready  = a_rdy;
    assign b.ready  = b_rdy;
    assign a.rvalid = resp && !id_q;
    assign b.rvalid = resp &&  id_q;
    assign a.rdata  = (resp && !id_q) ? rdata_q : '0;
    assign b.rdata  = (resp &&  id_q) ? rdata_q : '0;
    assign a.rerr   = resp && !id_q && rerr_q;
    assign b.rerr   = resp &&  id_q && rerr_q;
    assign word     = word_q;
    assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_partsel_rmw_arbiter.sv
// Scoreboard bench: two engines (INIT = 0 and INIT = 32'h12345678) driven by
// directed and random requests, checked against a bit-level reference model.
module tb_partsel_rmw_arbiter;
    localparam int          DW    = 32;
    localparam int          FW    = 8;
    localparam int          OW    = 5;
    localparam int          LW    = 3;
    localparam logic [31:0] INIT0 = 32'h0;
    localparam logic [31:0] INIT1 = 32'h12345678;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    partsel_rmw_arbiter_if #(.FW(FW), .OW(OW), .LW(LW)) i0a ();
    partsel_rmw_arbiter_if #(.FW(FW), .OW(OW), .LW(LW)) i0b ();
    partsel_rmw_arbiter_if #(.FW(FW), .OW(OW), .LW(LW)) i1a ();
    partsel_rmw_arbiter_if #(.FW(FW), .OW(OW), .LW(LW)) i1b ();
    logic [DW-1:0] w0, w1;
    logic          busy0, busy1;

    partsel_rmw_arbiter #(.DW(DW), .FW(FW), .INIT(INIT0)) dut0 (
        .clk(clk), .rst(rst), .a(i0a), .b(i0b), .word(w0), .busy(busy0));
    partsel_rmw_arbiter #(.DW(DW), .FW(FW), .INIT(INIT1)) dut1 (
        .clk(clk), .rst(rst), .a(i1a), .b(i1b), .word(w1), .busy(busy1));

    typedef struct {
        int          port;
        int          cyc;
        logic [7:0]  rd;
        bit          err;
        logic [31:0] w;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mw[2];
    int          grant_log[$];
    int          hs_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int p, input bit wr, input int off, input int len, input logic [7:0] wd);
        case (p)
            0: begin i0a.write = wr; i0a.offset = 5'(off); i0a.len = 3'(len); i0a.wdata = wd; i0a.valid = 1'b1; end
            1: begin i0b.write = wr; i0b.offset = 5'(off); i0b.len = 3'(len); i0b.wdata = wd; i0b.valid = 1'b1; end
            2: begin i1a.write = wr; i1a.offset = 5'(off); i1a.len = 3'(len); i1a.wdata = wd; i1a.valid = 1'b1; end
            default: begin i1b.write = wr; i1b.offset = 5'(off); i1b.len = 3'(len); i1b.wdata = wd; i1b.valid = 1'b1; end
        endcase
    endtask

    task automatic set_valid(input int p, input logic v);
        case (p)
            0: i0a.valid = v;
            1: i0b.valid = v;
            2: i1a.valid = v;
            default: i1b.valid = v;
        endcase
    endtask

    function automatic logic get_ready(input int p);
        case (p)
            0: return i0a.ready;
            1: return i0b.ready;
            2: return i1a.ready;
            default: return i1b.ready;
        endcase
    endfunction

    // Reference: walk the field bit by bit; positions past DW-1 read 0 and are not written
    task automatic model_op(input int d, input bit wr, input int off, input int len,
                            input logic [7:0] wd, output logic [7:0] rd, output bit err);
        rd  = 8'h00;
        err = (off + len + 1) > DW;
        for (int i = 0; i <= len; i++) begin
            if (off + i < DW) begin
                rd[i] = mw[d][off + i];
                if (wr) mw[d][off + i] = wd[i];
            end
        end
    endtask

    // Present a request and return just after the handshake edge, valid still high
    task automatic issue(input int p, input bit wr, input int off, input int len, input logic [7:0] wd);
        int         guard;
        bit         done;
        logic [7:0] rd;
        bit         err;
        exp_t       e;
        guard = 0;
        done  = 0;
        set_req(p, wr, off, len, wd);
        while (!done) begin
            @(negedge clk);
            if (get_ready(p)) begin
                model_op(p / 2, wr, off, len, wd, rd, err);
                e.port = p; e.cyc = cyc + 2; e.rd = rd; e.err = err; e.w = mw[p / 2];
                exp_q.push_back(e);
                if (p < 2) begin
                    grant_log.push_back(p);
                    hs_log.push_back(cyc);
                end
                done = 1;
            end else if (++guard > 200) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout port%0d: got no ready in 200 cycles, required a grant", p);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int p, input logic rv, input logic [7:0] rd, input logic re, input logic [31:0] w);
        int   idx;
        exp_t e;
        if (rv) begin
            idx = -1;
            foreach (exp_q[i]) if (idx < 0 && exp_q[i].port == p) idx = i;
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected port%0d: got rvalid 1 required 0 (cycle %0d)", p, cyc);
            end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                chk($sformatf("resp_cycle_p%0d", p), cyc, e.cyc);
                chk($sformatf("rdata_p%0d", p), {24'h0, rd}, {24'h0, e.rd});
                chk($sformatf("rerr_p%0d", p), {31'h0, re}, {31'h0, e.err});
                chk($sformatf("word_at_resp_p%0d", p), w, e.w);
            end
        end
    endtask

    always @(negedge clk) begin
        int k;
        mon(0, i0a.rvalid, i0a.rdata, i0a.rerr, w0);
        mon(1, i0b.rvalid, i0b.rdata, i0b.rerr, w0);
        mon(2, i1a.rvalid, i1a.rdata, i1a.rerr, w1);
        mon(3, i1b.rvalid, i1b.rdata, i1b.rerr, w1);
        k = 0;
        while (k < exp_q.size()) begin
            if (exp_q[k].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL resp_missing port%0d: got no rvalid by cycle %0d, required at cycle %0d",
                         exp_q[k].port, cyc, exp_q[k].cyc);
                exp_q.delete(k);
            end else begin
                k++;
            end
        end
        chk("ready_excl0", {31'h0, i0a.ready & i0b.ready}, 32'h0);
        chk("ready_busy0", {31'h0, (i0a.ready | i0b.ready) & busy0}, 32'h0);
        chk("ready_excl1", {31'h0, i1a.ready & i1b.ready}, 32'h0);
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy0 || busy1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending responses, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_seq(input int p, input int n);
        int off, len, gap;
        bit wr;
        for (int k = 0; k < n; k++) begin
            wr  = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DW - FW, DW - 1))
                                             : int'($urandom_range(0, DW - 1));
            len = $urandom_range(0, FW - 1);
            issue(p, wr, off, len, 8'($urandom));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_valid(p, 1'b0);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        set_valid(p, 1'b0);
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            set_req(p, 1'b0, 0, 0, 8'h00);
            set_valid(p, 1'b0);
        end
        mw[0] = INIT0;
        mw[1] = INIT1;

        repeat (3) @(negedge clk);
        chk("rst_word0", w0, INIT0);
        chk("rst_word1", w1, INIT1);
        chk("rst_busy", {30'h0, busy0, busy1}, 32'h0);
        chk("rst_ready", {28'h0, i0a.ready, i0b.ready, i1a.ready, i1b.ready}, 32'h0);
        chk("rst_rvalid", {28'h0, i0a.rvalid, i0b.rvalid, i1a.rvalid, i1b.rvalid}, 32'h0);
        chk("rst_rdata", {i0a.rdata, i0b.rdata, i1a.rdata, i1b.rdata}, 32'h0);
        chk("rst_rerr", {28'h0, i0a.rerr, i0b.rerr, i1a.rerr, i1b.rerr}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Tie from reset: both held valid, expect A, B, A, B at 3-cycle spacing
        fork
            begin issue(0, 1'b0, 3, 2, 8'h00); issue(0, 1'b0, 9, 7, 8'h00); set_valid(0, 1'b0); end
            begin issue(1, 1'b0, 0, 7, 8'h00); issue(1, 1'b0, 27, 4, 8'h00); set_valid(1, 1'b0); end
        join
        wait_idle();
        chk("tie_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            chk("tie_grant0", grant_log[0], 0);
            chk("tie_grant1", grant_log[1], 1);
            chk("tie_grant2", grant_log[2], 0);
            chk("tie_grant3", grant_log[3], 1);
            for (int i = 1; i < 4; i++) chk("tie_spacing", hs_log[i] - hs_log[i-1], 3);
        end

        issue(0, 1'b1, 4, 3, 8'hFA); set_valid(0, 1'b0);
        wait_idle();
        chk("insert_word", w0, 32'h000000A0);
        issue(0, 1'b0, 4, 3, 8'h00); set_valid(0, 1'b0);
        wait_idle();

        issue(2, 1'b0, 0, 7, 8'h00); set_valid(2, 1'b0);
        issue(3, 1'b0, 28, 3, 8'h00); set_valid(3, 1'b0);
        wait_idle();
        chk("init_word1", w1, INIT1);

        issue(0, 1'b1, 30, 3, 8'hFF); set_valid(0, 1'b0);
        wait_idle();
        chk("top_write_word", w0, 32'hC00000A0);
        issue(0, 1'b0, 30, 3, 8'h00); set_valid(0, 1'b0);
        wait_idle();

        fork
            rand_seq(0, 30);
            rand_seq(1, 30);
            rand_seq(2, 30);
            rand_seq(3, 30);
        join
        wait_idle();
        chk("rand_word0", w0, mw[0]);
        chk("rand_word1", w1, mw[1]);

        // Reset in EXEC: word returns to INIT at once and the response is dropped
        issue(0, 1'b1, 0, 7, 8'hA5); set_valid(0, 1'b0);
        wait_idle();
        issue(0, 1'b1, 8, 7, 8'h5C); set_valid(0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        mw[0] = INIT0;
        mw[1] = INIT1;
        #1;
        chk("abort_word0", w0, INIT0);
        chk("abort_word1", w1, INIT1);
        chk("abort_busy", {30'h0, busy0, busy1}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        issue(0, 1'b1, 0, 7, 8'h3C); set_valid(0, 1'b0);
        issue(0, 1'b0, 0, 7, 8'h00); set_valid(0, 1'b0);
        wait_idle();
        chk("post_abort_word0", w0, 32'h0000003C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
